// File: rtl/seg7_scan.sv
// Two-digit multiplexed 7-segment scanner with frame-synchronous digit updates.
// Optional LEADING_ZERO_BLANK_EN macro blanks the tens digit while it is zero.
module seg7_scan #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame
);

  localparam int unsigned MAX_LEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {
    SHOW_ONES = 2'd0,
    BLANK1    = 2'd1,
    SHOW_TENS = 2'd2,
    BLANK2    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       disp_ones_q, disp_tens_q;
  logic [3:0]       pend_ones_q, pend_tens_q;
  logic             pend_vld_q;
  logic             last_c;
  logic             boundary_c;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign last_c     = (cnt_q == '0);
  assign boundary_c = (state_q == SHOW_ONES) && (cnt_q == SHOW_LOAD);

  // Sequencer: one down-counter reloaded on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    if (last_c) begin
      case (state_q)
        SHOW_ONES: state_d = HAS_BLANK ? BLANK1 : SHOW_TENS;
        BLANK1:    state_d = SHOW_TENS;
        SHOW_TENS: state_d = HAS_BLANK ? BLANK2 : SHOW_ONES;
        default:   state_d = SHOW_ONES;
      endcase
      cnt_d = ((state_d == SHOW_ONES) || (state_d == SHOW_TENS)) ? SHOW_LOAD : BLANK_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SHOW_ONES;
      cnt_q       <= SHOW_LOAD;
      disp_ones_q <= 4'd0;
      disp_tens_q <= 4'd0;
      pend_ones_q <= 4'd0;
      pend_tens_q <= 4'd0;
      pend_vld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Digits only change at the frame boundary; a boundary load bypasses pending.
      if (boundary_c) begin
        if (load) begin
          disp_ones_q <= ones;
          disp_tens_q <= tens;
        end else if (pend_vld_q) begin
          disp_ones_q <= pend_ones_q;
          disp_tens_q <= pend_tens_q;
        end
        pend_vld_q <= 1'b0;
      end else if (load) begin
        pend_ones_q <= ones;
        pend_tens_q <= tens;
        pend_vld_q  <= 1'b1;
      end
    end
  end

  assign frame = last_c && (HAS_BLANK ? (state_q == BLANK2) : (state_q == SHOW_TENS));

  // Display drive from registered state only.
  always_comb begin
    an  = 2'b11;
    seg = 7'h7F;
    case (state_q)
      SHOW_ONES: begin
        an  = 2'b10;
        seg = decode(disp_ones_q);
      end
      SHOW_TENS: begin
        an  = 2'b01;
        seg = decode(disp_tens_q);
`ifdef LEADING_ZERO_BLANK_EN
        if (disp_tens_q == 4'd0) begin
          an  = 2'b11;
          seg = 7'h7F;
        end
`endif
      end
      default: begin
        an  = 2'b11;
        seg = 7'h7F;
      end
    endcase
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (with and without blank states) against a
// frame-position reference model, plus table vectors and directed corner cases.
module tb_seg7_scan;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       reset, load;
  logic [3:0] ones, tens;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       frame_a, frame_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .load(load), .ones(ones), .tens(tens),
    .seg(seg_a), .an(an_a), .frame(frame_a));

  seg7_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .load(load), .ones(ones), .tens(tens),
    .seg(seg_b), .an(an_b), .frame(frame_b));

  // Reference model state, index 0 = one blank cycle, index 1 = no blanks.
  int         pos [2];
  logic [3:0] m_do[2], m_dt[2], m_po[2], m_pt[2];
  bit         m_pv[2];

  logic [6:0] pat [16];
  initial begin
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30;
    pat[4] = 7'h19; pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78;
    pat[8] = 7'h00; pat[9] = 7'h10;
    for (int i = 10; i < 16; i++) pat[i] = 7'h3F;
  end

  function automatic int blen(input int c);
    return (c == 0) ? 1 : 0;
  endfunction

  task automatic model_edge(input int c, input bit rst, input bit ld,
                            input logic [3:0] o, input logic [3:0] t);
    int flen;
    flen = 2 * (R + blen(c));
    if (rst) begin
      pos[c] = 0; m_do[c] = 0; m_dt[c] = 0; m_po[c] = 0; m_pt[c] = 0; m_pv[c] = 0;
    end else begin
      if (pos[c] == 0) begin
        if (ld) begin m_do[c] = o; m_dt[c] = t; end
        else if (m_pv[c]) begin m_do[c] = m_po[c]; m_dt[c] = m_pt[c]; end
        m_pv[c] = 0;
      end else if (ld) begin
        m_po[c] = o; m_pt[c] = t; m_pv[c] = 1;
      end
      pos[c] = (pos[c] + 1) % flen;
    end
  endtask

  task automatic model_out(input int c, output logic [1:0] e_an,
                           output logic [6:0] e_seg, output logic e_fr);
    int b, p;
    b = blen(c);
    p = pos[c];
    e_fr = (p == 2 * (R + b) - 1);
    e_an = 2'b11; e_seg = 7'h7F;
    if (p < R) begin
      e_an = 2'b10; e_seg = pat[m_do[c]];
    end else if (p >= R + b && p < 2 * R + b) begin
      e_an = 2'b01; e_seg = pat[m_dt[c]];
`ifdef LEADING_ZERO_BLANK_EN
      if (m_dt[c] == 4'd0) begin e_an = 2'b11; e_seg = 7'h7F; end
`endif
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, update models, compare both DUTs.
  task automatic step(input bit rst, input bit ld, input logic [3:0] o, input logic [3:0] t);
    logic [1:0] e_an;
    logic [6:0] e_seg;
    logic       e_fr;
    reset = rst; load = ld; ones = o; tens = t;
    @(posedge clk);
    model_edge(0, rst, ld, o, t);
    model_edge(1, rst, ld, o, t);
    #1;
    model_out(0, e_an, e_seg, e_fr);
    chk("a_an", 8'(an_a), 8'(e_an));
    chk("a_seg", 8'(seg_a), 8'(e_seg));
    chk("a_frame", 8'(frame_a), 8'(e_fr));
    model_out(1, e_an, e_seg, e_fr);
    chk("b_an", 8'(an_b), 8'(e_an));
    chk("b_seg", 8'(seg_b), 8'(e_seg));
    chk("b_frame", 8'(frame_b), 8'(e_fr));
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 4'd0);
  endtask

  typedef struct {
    bit         rst;
    bit         ld;
    logic [3:0] o;
    logic [3:0] t;
    logic [1:0] an;
    logic [6:0] seg;
    bit         fr;
  } vec_t;

  vec_t tbl[11];
  bit   seen9;
  int   nframe, nblank;

  initial begin
    reset = 1'b1; load = 1'b0; ones = 4'd0; tens = 4'd0;
    for (int c = 0; c < 2; c++) begin
      pos[c] = 0; m_do[c] = 0; m_dt[c] = 0; m_po[c] = 0; m_pt[c] = 0; m_pv[c] = 0;
    end

    // Reset release with no load: one full frame plus the wrap.
    tbl[0]  = '{1, 0, 4'd0, 4'd0, 2'b10, 7'h40, 0};
    tbl[1]  = '{0, 0, 4'd0, 4'd0, 2'b10, 7'h40, 0};
    tbl[2]  = '{0, 0, 4'd0, 4'd0, 2'b10, 7'h40, 0};
    tbl[3]  = '{0, 0, 4'd0, 4'd0, 2'b10, 7'h40, 0};
    tbl[4]  = '{0, 0, 4'd0, 4'd0, 2'b11, 7'h7F, 0};
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 5; i < 9; i++) tbl[i] = '{0, 0, 4'd0, 4'd0, 2'b11, 7'h7F, 0};
`else
    for (int i = 5; i < 9; i++) tbl[i] = '{0, 0, 4'd0, 4'd0, 2'b01, 7'h40, 0};
`endif
    tbl[9]  = '{0, 0, 4'd0, 4'd0, 2'b11, 7'h7F, 1};
    tbl[10] = '{0, 0, 4'd0, 4'd0, 2'b10, 7'h40, 0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].ld, tbl[i].o, tbl[i].t);
      chk("tbl_an", 8'(an_a), 8'(tbl[i].an));
      chk("tbl_seg", 8'(seg_a), 8'(tbl[i].seg));
      chk("tbl_frame", 8'(frame_a), 8'(tbl[i].fr));
    end

    // Mid-frame load 7/4 at frame cycle 3 takes effect next frame only.
    adv(3);
    step(0, 1, 4'd7, 4'd4);
    adv(1);
`ifndef LEADING_ZERO_BLANK_EN
    chk("midload_cur_tens", 8'(seg_a), 8'h40);
`endif
    adv(6);
    chk("midload_next_ones", 8'(seg_a), 8'h78);
    adv(4);
    chk("midload_next_tens", 8'(seg_a), 8'h19);
    chk("midload_next_an", 8'(an_a), 8'h01);

    // Two loads in one frame: last wins.
    step(0, 1, 4'd1, 4'd2);
    step(0, 0, 4'd0, 4'd0);
    step(0, 1, 4'd3, 4'd4);
    adv(3);
    chk("lastwins_ones", 8'(seg_a), 8'h30);
    adv(4);
    chk("lastwins_tens", 8'(seg_a), 8'h19);

    // Load exactly on the boundary cycle shows in the same SHOW_ONES.
    adv(5);
    step(0, 1, 4'd12, 4'd0);
    chk("boundary_dash", 8'(seg_a), 8'h3F);
    chk("boundary_an", 8'(an_a), 8'h02);
    adv(4);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_an", 8'(an_a), 8'h03);
    chk("lz_seg", 8'(seg_a), 8'h7F);
`else
    chk("zero_tens_an", 8'(an_a), 8'h01);
    chk("zero_tens_seg", 8'(seg_a), 8'h40);
`endif

    // Reset mid SHOW_TENS with 9/9 pending: 9/9 must never appear.
    step(0, 1, 4'd9, 4'd9);
    step(1, 0, 4'd0, 4'd0);
    chk("rst_an", 8'(an_a), 8'h02);
    chk("rst_seg", 8'(seg_a), 8'h40);
    chk("rst_frame", 8'(frame_a), 8'h00);
    seen9 = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 4'd0, 4'd0);
      if (seg_a == 7'h10 || seg_b == 7'h10) seen9 = 1;
    end
    chk("rst_no_nine", 8'(seen9), 8'h00);

    // No-blank instance: 8-cycle frame, an never 11 (except leading-zero blank).
    step(1, 0, 4'd0, 4'd5);
    step(0, 1, 4'd0, 4'd5);
    nframe = 0; nblank = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 4'd0, 4'd0);
      if (frame_b) nframe++;
      if (an_b == 2'b11) nblank++;
    end
    chk("b_frame_count", 8'(nframe), 8'd5);
    chk("b_no_blank", 8'(nblank), 8'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is lit; legal range >= 1.
REQ-002 SHALL have parameter BLANK_CYCLES, default 500, clock cycles of all-off dead time after each digit; 0 removes the blank states.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port load  input  1  one-cycle strobe that captures ones/tens.
REQ-006 SHALL have port ones  input  4  BCD ones digit (out1 of the binary-to-BCD converter).
REQ-007 SHALL have port tens  input  4  BCD tens digit (out2 of the binary-to-BCD converter).
REQ-008 SHALL have port seg  output  7  segment drive, active-low, seg[0]=a through seg[6]=g.
REQ-009 SHALL have port an  output  2  digit enables, active-low, an[0]=ones, an[1]=tens.
REQ-010 SHALL have port frame  output  1  one-cycle pulse on the last cycle of each full scan frame.

Function
REQ-011 SHALL implement the FSM states SHOW_ONES -> BLANK1 -> SHOW_TENS -> BLANK2 -> SHOW_ONES.
REQ-012 SHALL hold each SHOW state for exactly REFRESH_DIV cycles and each BLANK state for exactly BLANK_CYCLES cycles, using one down-counter or up-counter reloaded on every state change.
REQ-013 SHALL skip BLANK1 and BLANK2 when BLANK_CYCLES=0, giving SHOW_ONES -> SHOW_TENS -> SHOW_ONES.
REQ-014 SHALL give a frame length of 2*(REFRESH_DIV+BLANK_CYCLES) cycles.
REQ-015 SHALL assert frame on the final cycle of BLANK2, or on the final cycle of SHOW_TENS when BLANK_CYCLES=0.
REQ-016 SHALL drive the active digit (an=2'b10 or 2'b01) in SHOW states, and an=2'b11 with seg=7'h7F in BLANK states.
REQ-017 SHALL latch ones/tens into a pending register pair on load, and set a pending flag.
REQ-018 SHALL copy pending digits into the display registers on the first cycle of SHOW_ONES (the frame boundary), then clear the pending flag; a mid-frame load never changes the digits of the current frame.
REQ-019 SHALL apply last-wins when load repeats while pending is set; the earlier pending values are discarded.
REQ-020 SHALL copy the load-cycle inputs straight into the display registers when load coincides with the frame-boundary cycle; pending stays clear.
REQ-021 SHALL decode digits 0-9 to standard active-low patterns (0=7'b1000000, 1=7'b1111001, 5=7'b0010010, 8=7'b0000000).
REQ-022 SHALL decode digits 10-15 to a dash, 7'b0111111 (only g lit).
REQ-023 SHALL drive seg and an combinationally from registered state and display digits only; no input-to-output combinational path.

Reset
REQ-024 SHALL, while reset is high at a clock edge, set state=SHOW_ONES, counter to its reload value, display and pending digits to 0, and pending flag to 0.
REQ-025 SHALL show an=2'b10, seg=7'b1000000, frame=0 in the cycle after reset.
REQ-026 SHALL give reset priority over load and abandon any scan or pending load in progress.

Configuration
REQ-027 SHALL, with macro LEADING_ZERO_BLANK_EN defined, force an=2'b11 and seg=7'h7F during SHOW_TENS whenever the displayed tens digit is 0; timing and frame are unchanged.
REQ-028 SHALL, with LEADING_ZERO_BLANK_EN undefined, display a tens digit of 0 as '0' like any other digit.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1)
REQ-029 SHALL cover reset release with no load: an sequence 10,10,10,10,11,01,01,01,01,11 repeats; seg during SHOW states is 7'b1000000; frame high every 10th cycle.
REQ-030 SHALL cover load ones=7, tens=4 at frame cycle 3: the current frame keeps showing 0/0; the next SHOW_ONES shows seg=7'b1111000, then SHOW_TENS shows 7'b0011001.
REQ-031 SHALL cover loads 1/2 then 3/4 in the same frame: the next frame shows 3/4 only.
REQ-032 SHALL cover load ones=12 exactly on the boundary cycle: the dash 7'b0111111 appears in that same SHOW_ONES; tens input 0 shows '0', or is blanked (an=2'b11) with LEADING_ZERO_BLANK_EN.
REQ-033 SHALL cover reset asserted mid-SHOW_TENS with pending 9/9: next cycle an=2'b10, seg='0', and 9/9 never appears.
REQ-034 SHALL cover BLANK_CYCLES=0: an alternates 10/01 every 4 cycles, an=2'b11 never appears, and frame has an 8-cycle period.
